// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and default widths.
package hazard_control_pkg;
  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MDU_WAIT = 1'b1
  } hz_state_t;

  localparam int HZ_CNT_W   = 32;
  localparam int WORD_WIDTH = 32;
endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter: increments once per cycle with inc high, holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/hazard_control.sv
// Pipeline stall/flush controller: same-cycle stage controls from hazards, MDU wait FSM
// and saturating stall/flush event counters.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int CNT_W = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ex_hazard,
  input  logic             branch_mispredict,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  hz_state_t state, state_nxt;
  logic      done_pending, done_pending_nxt;
  logic      freeze, mdu_hold;

  assign freeze   = dmem_req && !dmem_ready;
  assign mdu_hold = ((state == HZ_RUN) && mdu_start && !mdu_done) ||
                    ((state == HZ_MDU_WAIT) && !(mdu_done || done_pending));
  assign mdu_busy = (state == HZ_MDU_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HZ_RUN;
      done_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_pending <= done_pending_nxt;
    end
  end

  // The FSM keeps advancing under freeze; a done seen while frozen is parked in done_pending.
  always_comb begin
    state_nxt        = state;
    done_pending_nxt = done_pending;
    case (state)
      HZ_RUN: begin
        done_pending_nxt = 1'b0;
        if (mdu_start && !mdu_done) state_nxt = HZ_MDU_WAIT;
      end
      HZ_MDU_WAIT: begin
        if ((mdu_done || done_pending) && !freeze) begin
          state_nxt        = HZ_RUN;
          done_pending_nxt = 1'b0;
        end else if (mdu_done && freeze) begin
          done_pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt        = HZ_RUN;
        done_pending_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;
    if (freeze) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (mdu_hold || mem_ex_hazard) begin
      // Load-use also suppresses mispredict: branch operands are stale this cycle.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_flush = 1'b1;
    end else if (branch_mispredict) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_redirect),
    .count (flush_events)
  );
endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Consumes hazard indications from the EX-stage forwarding unit: the load-use hazard, raised when the EX/MEM producer writes back from memory.
- Also consumes branch mispredict (EX), multi-cycle MDU ops (EX) and data-memory wait (MEM).
- Drives per-stage stall (hold) and flush (bubble) enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus saturating performance counters.

Parameters:
CNT_W, 32, width of stall_cycles and flush_events counters.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_ex_hazard  input  1  load-use hazard: EX needs a value still being loaded by the instruction in MEM
branch_mispredict  input  1  EX-resolved branch/jump disagrees with fetched path
mdu_start  input  1  one-cycle pulse: multi-cycle mul/div issued from EX
mdu_done  input  1  one-cycle pulse: MDU result valid
dmem_req  input  1  MEM stage is performing a load/store
dmem_ready  input  1  data memory completes this cycle
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID
ifid_flush  output  1  load bubble into IF/ID
idex_stall  output  1  hold ID/EX
idex_flush  output  1  load bubble into ID/EX
exmem_stall  output  1  hold EX/MEM
exmem_flush  output  1  load bubble into EX/MEM
memwb_flush  output  1  load bubble into MEM/WB
pc_redirect  output  1  PC takes EX-computed target
mdu_busy  output  1  FSM in MDU_WAIT
stall_cycles  output  CNT_W  cycles with pc_stall=1
flush_events  output  CNT_W  cycles with pc_redirect=1

Behaviour:
- Reset (async, rst=1):
  - state=RUN, done_pending=0, counters=0.
  - All stage-control outputs are decoded combinationally from state and inputs, so with reset held and inputs idle they read 0.
- FSM states: RUN, MDU_WAIT. mdu_busy = (state==MDU_WAIT).
- freeze = dmem_req && !dmem_ready. Highest priority.
  - Asserts pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush.
  - Forces all other flushes and pc_redirect to 0.
  - The FSM still advances; see done_pending.
- mdu_hold = (RUN && mdu_start && !mdu_done) || (MDU_WAIT && !(mdu_done || done_pending)).
  - When not frozen: pc_stall, ifid_stall, idex_stall, exmem_flush.
- Load-use, applied when not frozen and not mdu_hold, and mem_ex_hazard=1:
  - pc_stall, ifid_stall, idex_stall, exmem_flush for exactly that cycle.
  - The hazard naturally drops the next cycle, when the load reaches MEM/WB and MEM-EX forwarding supplies the value.
  - No state is kept.
- Mispredict, applied when not frozen, not mdu_hold, no mem_ex_hazard, and branch_mispredict=1:
  - pc_redirect, ifid_flush, idex_flush.
  - A load-use hazard suppresses mispredict because the branch operands are invalid that cycle; the branch re-resolves next cycle.
- Transitions:
  - RUN -> MDU_WAIT on mdu_start && !mdu_done.
  - mdu_start && mdu_done in the same cycle: stay in RUN, no stall.
  - MDU_WAIT -> RUN on (mdu_done || done_pending) && !freeze.
- done_pending:
  - Set when mdu_done arrives while freeze=1 in MDU_WAIT.
  - Cleared on the MDU_WAIT exit.
  - Guarantees a done pulse is never lost.
- mdu_start while in MDU_WAIT is ignored (illegal; the bench asserts it never occurs).
- Counters: registered, increment by 1 on the clock edge after a cycle where the condition holds, saturate at all-ones (no wrap).
- Reset mid-MDU_WAIT: returns to RUN immediately, done_pending cleared.
- Latency: all stage controls are same-cycle (Mealy). The state register adds one cycle only to MDU_WAIT exit bookkeeping.

Decomposition:
- Shared defines file:
  - hazard state encodings HZ_RUN=1'b0, HZ_MDU_WAIT=1'b1
  - HZ_CNT_W default 32
  - existing WORD_WIDTH
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice.

Test Plan:
1. Reset: rst=1 for 2 cycles with inputs idle -> all controls 0, stall_cycles=0, flush_events=0, mdu_busy=0.
2. Load-use: mem_ex_hazard=1 for 1 cycle -> pc_stall, ifid_stall, idex_stall, exmem_flush=1 that cycle only; stall_cycles=1 afterwards.
3. Hazard plus mispredict in the same cycle -> stall outputs only, pc_redirect=0. Next cycle mispredict alone -> pc_redirect, ifid_flush, idex_flush=1; flush_events=1.
4. MDU: mdu_start at cycle 0, mdu_done at cycle 5 -> stalls in cycles 0-4, released in cycle 5, mdu_busy in cycles 1-5, stall_cycles=5.
5. Done during freeze: in MDU_WAIT, dmem_req=1/dmem_ready=0 for 3 cycles with mdu_done in the 2nd -> freeze outputs for 3 cycles, then released with no extra stall, state RUN.
6. Saturation: force 2^CNT_W+3 stall cycles with CNT_W=4 -> stall_cycles holds 4'hF. Async rst mid-MDU_WAIT -> RUN, counters 0 without a clock edge.
